// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake plus the narrow link to the external 4-bit adder.
// slave is the sequencer's view; master is the operand source, result sink and adder.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;

    logic [3:0]   adder_a;
    logic [3:0]   adder_b;
    logic         adder_cin;
    logic [3:0]   adder_s;
    logic         adder_co;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    modport slave (
        input  in_valid, op_a, op_b, cin, adder_s, adder_co, out_ready,
        output in_ready, adder_a, adder_b, adder_cin, out_valid, sum, cout
    );

    modport master (
        output in_valid, op_a, op_b, cin, adder_s, adder_co, out_ready,
        input  in_ready, adder_a, adder_b, adder_cin, out_valid, sum, cout
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a wide add through an external 4-bit adder, LSB nibble first,
// one nibble per clock, carrying between slices in a register.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    nibble_serial_adder_ctrl_if.slave      bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic               r_cin;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_sum;
    logic               r_cout;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_a_sel;
    logic [3:0]         w_b_sel;
    logic [3:0]         w_adder_a;
    logic [3:0]         w_adder_b;
    logic               w_adder_cin;

    assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_accept = bus.in_valid & w_in_ready;

    // Nibble mux written as a compare loop so any NIBBLES works without width games.
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_a_sel = r_op_a[4*n +: 4];
                w_b_sel = r_op_b[4*n +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Handshake outputs depend only on state, never on in_valid/out_ready.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_adder_a   = 4'd0;
        w_adder_b   = 4'd0;
        w_adder_cin = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_adder_a   = w_a_sel;
                w_adder_b   = w_b_sel;
                w_adder_cin = (r_idx == '0) ? r_cin : r_carry;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: sum is only written in RUN, so it holds the last result afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_cin   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a <= bus.op_a;
                r_op_b <= bus.op_b;
                r_cin  <= bus.cin;
                r_idx  <= '0;
            end
            if (r_state == S_RUN) begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (r_idx == IDX_W'(n)) r_sum[4*n +: 4] <= bus.adder_s;
                end
                r_carry <= bus.adder_co;
                if (w_last) r_cout <= bus.adder_co;
                else        r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.adder_a   = w_adder_a;
    assign bus.adder_b   = w_adder_b;
    assign bus.adder_cin = w_adder_cin;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Drives directed and random wide adds through the sequencer with a behavioural
// 4-bit adder on its adder port, checking against plain a+b+cin arithmetic.
module tb_nibble_serial_adder_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.NIBBLES(NIB)) bus();

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The team's combinational 4-bit adder.
    assign {bus.adder_co, bus.adder_s} = 5'(bus.adder_a) + 5'(bus.adder_b) + 5'(bus.adder_cin);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Carry into nibble n of a+b+c, from the sum of the low 4n bits.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int n);
        logic [63:0] m;
        logic [63:0] s;
        m = (64'd1 << (4 * n)) - 64'd1;
        s = (64'(a) & m) + (64'(b) & m) + 64'(c);
        return s[4*n];
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int stall, input bit poke);
        logic [W:0]   exp_r;
        logic [W-1:0] a_nib;
        int           k;
        exp_r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.cin      = c;
        chk("rdy_idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = poke;
        if (poke) begin
            bus.op_a = W'($urandom);
            bus.op_b = W'($urandom);
            bus.cin  = 1'($urandom);
        end
        // Cycles after the accept edge: 1..NIB are RUN, NIB+1 is the first DONE cycle.
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (bus.out_valid) break;
            if (k <= NIB) begin
                a_nib = a >> (4 * (k - 1));
                chk("cin_nib", 64'(bus.adder_cin), 64'(carry_into(a, b, c, k - 1)));
                chk("a_nib", 64'(bus.adder_a), 64'(a_nib[3:0]));
                chk("busy_rdy", 64'(bus.in_ready), 64'd0);
            end
        end
        chk("latency", 64'(k), 64'(NIB + 1));
        chk("sum", 64'(bus.sum), 64'(exp_r[W-1:0]));
        chk("cout", 64'(bus.cout), 64'(exp_r[W]));
        chk("idle_adder", 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_v", 64'(bus.out_valid), 64'd1);
            chk("hold_sum", 64'({bus.cout, bus.sum}), 64'(exp_r));
            chk("hold_rdy", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("drop_v", 64'(bus.out_valid), 64'd0);
        chk("back_rdy", 64'(bus.in_ready), 64'd1);
        chk("keep_sum", 64'({bus.cout, bus.sum}), 64'(exp_r));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_rdy", 64'(bus.in_ready), 64'd1);
        chk("rst_v", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'({bus.cout, bus.sum}), 64'd0);
        chk("rst_adder", 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 2, 1'b0);
        run_op(16'hA5C3, 16'h5A3C, 1'b1, 6, 1'b1);

        // Reset two RUN edges into an op; partial result must vanish.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_a     = 16'hABCD;
        bus.op_b     = 16'h1234;
        bus.cin      = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_sum", 64'({bus.cout, bus.sum}), 64'd0);
        chk("mid_rst_rdy", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_adder", 64'({bus.adder_a, bus.adder_b, bus.adder_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
